gcd_job_arbiter: RTL and testbench

//  Shares one ee354_GCD core among N_REQ requesters. Round-robin picks one pending job, launches
//  the core via Start, waits for q_Done, returns AB_GCD to the winner, then Acks the core back to I.

---
 rtl/gcd_job_arbiter_pkg.sv | 17 +
 rtl/gcd_job_arbiter_rr_picker.sv | 35 +++
 rtl/gcd_job_arbiter.sv | 173 +++++++++++++++++
 tb/tb_gcd_job_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/gcd_job_arbiter_pkg.sv
// Shared definitions for the GCD job arbiter: default sizes, operand width and FSM encoding.
package gcd_job_arbiter_pkg;

    localparam int unsigned OP_W      = 8;
    localparam int unsigned N_REQ_DEF = 4;
    localparam int unsigned CNT_W_DEF = 16;

    // One-hot arbiter states; anything else is treated as illegal and recovers to IDLE
    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_LAUNCH  = 5'b00010,
        ST_RUN     = 5'b00100,
        ST_COLLECT = 5'b01000,
        ST_REJECT  = 5'b10000
    } state_e;

endpackage

// File: rtl/gcd_job_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible request at or after rr_ptr, wrapping.
module gcd_job_arbiter_rr_picker
    import gcd_job_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    input  logic [N_REQ-1:0] mask,
    output logic             any_c,
    output logic [N_REQ-1:0] win_c,
    output logic [IDX_W-1:0] win_idx_c
);

    logic [N_REQ-1:0] eligible_c;
    int unsigned      cand_c;

    always_comb begin
        eligible_c = req & ~mask;
        any_c      = 1'b0;
        win_c      = '0;
        win_idx_c  = '0;
        cand_c     = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand_c = (32'(rr_ptr) + i) % N_REQ;
            if (!any_c && eligible_c[IDX_W'(cand_c)]) begin
                any_c                    = 1'b1;
                win_c[IDX_W'(cand_c)]    = 1'b1;
                win_idx_c                = IDX_W'(cand_c);
            end
        end
    end

endmodule

// File: rtl/gcd_job_arbiter.sv
// Shares one external GCD core among N_REQ requesters; zero-operand jobs are rejected locally.
module gcd_job_arbiter
    import gcd_job_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [N_REQ-1:0]      Req,
    input  logic [OP_W*N_REQ-1:0] Op_A,
    input  logic [OP_W*N_REQ-1:0] Op_B,
    input  logic                  Step_Mode,
    input  logic                  Step,
    output logic [N_REQ-1:0]      Gnt,
    output logic [N_REQ-1:0]      Resp_Valid,
    output logic [OP_W-1:0]       Result,
    output logic                  Err,
    output logic                  Busy,
    output logic [CNT_W-1:0]      Job_Cycles,
    output logic [OP_W-1:0]       core_Ain,
    output logic [OP_W-1:0]       core_Bin,
    output logic                  core_Start,
    output logic                  core_Ack,
    output logic                  core_SCEN,
    input  logic                  core_q_I,
    input  logic                  core_q_Done,
    input  logic [OP_W-1:0]       core_GCD
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [OP_W-1:0]    op_a_q, op_a_d, op_b_q, op_b_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d, resp_valid_q, resp_valid_d;
    logic [OP_W-1:0]    result_q, result_d;
    logic               err_q, err_d, busy_q, busy_d;
    logic [CNT_W-1:0]   job_cycles_q, job_cycles_d;
    logic               core_start_q, core_start_d, core_ack_q, core_ack_d;

    logic               pick_any_c;
    logic [N_REQ-1:0]   pick_win_c;
    logic [IDX_W-1:0]   pick_idx_c;
    logic [OP_W-1:0]    win_op_a_c, win_op_b_c;
    logic [IDX_W-1:0]   idx_inc_c;

    // A requester just answered may still hold Req for a cycle; keep it out of the pick
    gcd_job_arbiter_rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .req       (Req),
        .rr_ptr    (rr_ptr_q),
        .mask      (resp_valid_q),
        .any_c     (pick_any_c),
        .win_c     (pick_win_c),
        .win_idx_c (pick_idx_c)
    );

    assign win_op_a_c = Op_A[32'(pick_idx_c)*OP_W +: OP_W];
    assign win_op_b_c = Op_B[32'(pick_idx_c)*OP_W +: OP_W];
    assign idx_inc_c  = (32'(idx_q) == N_REQ - 1) ? '0 : IDX_W'(32'(idx_q) + 1);

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        idx_d        = idx_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        gnt_d        = '0;
        resp_valid_d = '0;
        result_d     = result_q;
        err_d        = err_q;
        busy_d       = busy_q;
        job_cycles_d = job_cycles_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any_c) begin
                    gnt_d   = pick_win_c;
                    idx_d   = pick_idx_c;
                    op_a_d  = win_op_a_c;
                    op_b_d  = win_op_b_c;
                    busy_d  = 1'b1;
                    state_d = (win_op_a_c == '0 || win_op_b_c == '0) ? ST_REJECT : ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (!core_q_I) begin
                    state_d      = ST_RUN;
                    job_cycles_d = '0;
                end
            end
            ST_RUN: begin
                if (job_cycles_q != '1) job_cycles_d = job_cycles_q + 1'b1;
                if (core_q_Done) begin
                    result_d            = core_GCD;
                    err_d               = 1'b0;
                    resp_valid_d[idx_q] = 1'b1;
                    state_d             = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (core_q_I) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = idx_inc_c;
                    busy_d   = 1'b0;
                end
            end
            ST_REJECT: begin
                result_d            = '0;
                err_d               = 1'b1;
                resp_valid_d[idx_q] = 1'b1;
                rr_ptr_d            = idx_inc_c;
                busy_d              = 1'b0;
                state_d             = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
        // Core handshakes are Moore outputs, registered from the next state
        core_start_d = (state_d == ST_LAUNCH);
        core_ack_d   = (state_d == ST_COLLECT);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            idx_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            gnt_q        <= '0;
            resp_valid_q <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            job_cycles_q <= '0;
            core_start_q <= 1'b0;
            core_ack_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            idx_q        <= idx_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            gnt_q        <= gnt_d;
            resp_valid_q <= resp_valid_d;
            result_q     <= result_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            job_cycles_q <= job_cycles_d;
            core_start_q <= core_start_d;
            core_ack_q   <= core_ack_d;
        end
    end

    assign Gnt        = gnt_q;
    assign Resp_Valid = resp_valid_q;
    assign Result     = result_q;
    assign Err        = err_q;
    assign Busy       = busy_q;
    assign Job_Cycles = job_cycles_q;
    assign core_Ain   = op_a_q;
    assign core_Bin   = op_b_q;
    assign core_Start = core_start_q;
    assign core_Ack   = core_ack_q;
    assign core_SCEN  = ~Step_Mode | Step;

endmodule

// File: tb/tb_gcd_job_arbiter.sv
// Directed bench for gcd_job_arbiter with a small subtractive GCD core model (I/SUB/DONE) attached.
module tb_gcd_job_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [3:0]  Req;
    logic [31:0] Op_A, Op_B;
    logic        Step_Mode, Step;
    logic [3:0]  Gnt, Resp_Valid;
    logic [7:0]  Result;
    logic        Err, Busy;
    logic [15:0] Job_Cycles;
    logic [7:0]  core_Ain, core_Bin, core_GCD;
    logic        core_Start, core_Ack, core_SCEN, core_q_I, core_q_Done;

    always #5 Clk = ~Clk;

    gcd_job_arbiter dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Op_A(Op_A), .Op_B(Op_B),
        .Step_Mode(Step_Mode), .Step(Step), .Gnt(Gnt), .Resp_Valid(Resp_Valid),
        .Result(Result), .Err(Err), .Busy(Busy), .Job_Cycles(Job_Cycles),
        .core_Ain(core_Ain), .core_Bin(core_Bin), .core_Start(core_Start),
        .core_Ack(core_Ack), .core_SCEN(core_SCEN), .core_q_I(core_q_I),
        .core_q_Done(core_q_Done), .core_GCD(core_GCD)
    );

    // Core model: Start loads operands in I, SUB subtracts when SCEN, DONE waits for Ack
    typedef enum logic [1:0] {C_I, C_SUB, C_DONE} cst_e;
    cst_e       cs;
    logic [7:0] ca, cb;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cs <= C_I; ca <= 8'd0; cb <= 8'd0;
        end else begin
            case (cs)
                C_I:    if (core_Start) begin ca <= core_Ain; cb <= core_Bin; cs <= C_SUB; end
                C_SUB:  if (core_SCEN) begin
                            if (ca == cb)     cs <= C_DONE;
                            else if (ca > cb) ca <= ca - cb;
                            else              cb <= cb - ca;
                        end
                C_DONE: if (core_Ack) cs <= C_I;
                default: cs <= C_I;
            endcase
        end
    end
    assign core_q_I    = (cs == C_I);
    assign core_q_Done = (cs == C_DONE);
    assign core_GCD    = ca;

    int errors = 0;
    int checks = 0;
    int cyc = 0, done_cyc = 0, sub_cnt = 0, start_cnt = 0;
    bit done_prev = 0, hold_all = 0, auto_step = 0;
    int gnt_log[$];
    int resp_idx[$], resp_res[$], resp_err[$], resp_jc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int oh2idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        Op_A[i*8 +: 8] = a;
        Op_B[i*8 +: 8] = b;
    endtask

    // One clock: sample at negedge, log grants/responses, act as the requesters
    task automatic step_cycle();
        @(negedge Clk);
        cyc++;
        if (Gnt != 4'd0) gnt_log.push_back(oh2idx(Gnt));
        if (core_q_Done && !done_prev) done_cyc = cyc;
        done_prev = core_q_Done;
        if (!core_q_I && !core_q_Done) sub_cnt++;
        if (core_Start) start_cnt++;
        if (Resp_Valid != 4'd0) begin
            resp_idx.push_back(oh2idx(Resp_Valid));
            resp_res.push_back(int'(Result));
            resp_err.push_back(int'(Err));
            resp_jc.push_back(int'(Job_Cycles));
            if (!Err) check("resp_after_done", 32'(cyc - done_cyc), 32'd1);
            if (!hold_all) Req = Req & ~Resp_Valid;
        end
        Step = (auto_step && (cyc % 20 == 0)) ? 1'b1 : 1'b0;
    endtask

    task automatic run_until_idle(input int max);
        bit ok = 0;
        for (int k = 0; k < max; k++) begin
            step_cycle();
            if (Req == 4'd0 && !Busy && Resp_Valid == 4'd0 && core_q_I) begin ok = 1; break; end
        end
        check("idle_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        int gb, rb;
        Reset = 1'b1; Req = 4'd0; Op_A = 32'd0; Op_B = 32'd0; Step_Mode = 1'b0; Step = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        step_cycle();
        check("rst_gnt", 32'(Gnt), 32'd0);
        check("rst_resp", 32'(Resp_Valid), 32'd0);
        check("rst_result_err_busy", {Result, Err, Busy}, 32'd0);
        check("rst_jobcycles", 32'(Job_Cycles), 32'd0);
        check("rst_core_io", {core_Ain, core_Bin, core_Start, core_Ack, core_q_I}, 32'd1);

        // Four simultaneous jobs served 0,1,2,3
        set_op(0, 8'd12, 8'd8); set_op(1, 8'd9, 8'd6); set_op(2, 8'd35, 8'd14); set_op(3, 8'd64, 8'd48);
        gb = gnt_log.size(); rb = resp_idx.size();
        Req = 4'b1111;
        run_until_idle(300);
        check("multi_ngrants", 32'(gnt_log.size() - gb), 32'd4);
        check("multi_nresp", 32'(resp_idx.size() - rb), 32'd4);
        if (gnt_log.size() - gb == 4 && resp_idx.size() - rb == 4) begin
            check("multi_gnt_order", {8'(gnt_log[gb]), 8'(gnt_log[gb+1]), 8'(gnt_log[gb+2]), 8'(gnt_log[gb+3])}, 32'h00010203);
            check("multi_resp_order", {8'(resp_idx[rb]), 8'(resp_idx[rb+1]), 8'(resp_idx[rb+2]), 8'(resp_idx[rb+3])}, 32'h00010203);
            check("multi_results", {8'(resp_res[rb]), 8'(resp_res[rb+1]), 8'(resp_res[rb+2]), 8'(resp_res[rb+3])}, {8'd4, 8'd3, 8'd7, 8'd16});
            check("multi_err", 32'(resp_err[rb] | resp_err[rb+1] | resp_err[rb+2] | resp_err[rb+3]), 32'd0);
        end

        // Single job Req0 (36,24): latency and result
        set_op(0, 8'd36, 8'd24);
        rb = resp_idx.size();
        Req = 4'b0001;
        step_cycle();
        check("single_gnt", 32'(Gnt), 32'b0001);
        check("single_start_t1", {Busy, core_Start}, 32'b11);
        step_cycle();
        check("single_start_t2", 32'(core_Start), 32'd1);
        run_until_idle(100);
        check("single_nresp", 32'(resp_idx.size() - rb), 32'd1);
        if (resp_idx.size() > rb) begin
            check("single_idx", 32'(resp_idx[rb]), 32'd0);
            check("single_result", 32'(resp_res[rb]), 32'd12);
            check("single_err", 32'(resp_err[rb]), 32'd0);
            check("single_jobcycles", 32'(resp_jc[rb]), 32'd3);
        end
        check("single_core_idle", 32'(core_q_I), 32'd1);

        // Zero operand rejected without touching the core
        set_op(2, 8'd7, 8'd0);
        start_cnt = 0;
        Req = 4'b0100;
        step_cycle();
        check("rej_gnt", 32'(Gnt), 32'b0100);
        step_cycle();
        check("rej_resp", 32'(Resp_Valid), 32'b0100);
        check("rej_result_err", {Result, Err}, {8'd0, 1'b1});
        check("rej_busy", 32'(Busy), 32'd0);
        repeat (4) step_cycle();
        check("rej_no_start", 32'(start_cnt), 32'd0);

        // Step mode: core parked in SUB until Step pulses arrive
        Step_Mode = 1'b1;
        set_op(1, 8'd6, 8'd4);
        rb = resp_idx.size(); sub_cnt = 0;
        Req = 4'b0010;
        repeat (30) step_cycle();
        check("step_noresp", 32'(resp_idx.size() - rb), 32'd0);
        check("step_core_sub", {core_q_I, core_q_Done, Busy, core_SCEN}, 32'b0010);
        auto_step = 1;
        run_until_idle(400);
        auto_step = 0;
        check("step_nresp", 32'(resp_idx.size() - rb), 32'd1);
        if (resp_idx.size() > rb) begin
            check("step_result", 32'(resp_res[rb]), 32'd2);
            check("step_jobcycles", 32'(resp_jc[rb]), 32'(sub_cnt));
        end

        // Reset while a job is in RUN
        rb = resp_idx.size();
        Req = 4'b0010;
        repeat (10) step_cycle();
        check("pre_rst_busy", 32'(Busy), 32'd1);
        Reset = 1'b1; Req = 4'd0;
        step_cycle();
        check("midrst_outs", {Gnt, Resp_Valid, Result, Err, Busy}, 32'd0);
        check("midrst_jc", 32'(Job_Cycles), 32'd0);
        check("midrst_core", {core_Start, core_Ack, core_q_I, core_Ain}, {1'b0, 1'b0, 1'b1, 8'd0});
        Reset = 1'b0; Step_Mode = 1'b0;
        step_cycle();
        check("midrst_nresp", 32'(resp_idx.size() - rb), 32'd0);
        set_op(3, 8'd5, 8'd5);
        Req = 4'b1000;
        run_until_idle(100);
        check("post_rst_nresp", 32'(resp_idx.size() - rb), 32'd1);
        if (resp_idx.size() > rb)
            check("post_rst_result", {8'(resp_idx[rb]), 8'(resp_res[rb])}, {8'd3, 8'd5});

        // Fairness: Req0 and Req1 held throughout
        set_op(0, 8'd36, 8'd24); set_op(1, 8'd9, 8'd6);
        gb = gnt_log.size();
        hold_all = 1;
        Req = 4'b0011;
        for (int k = 0; k < 300 && gnt_log.size() < gb + 4; k++) step_cycle();
        Req = 4'd0; hold_all = 0;
        run_until_idle(100);
        check("fair_ngrants", 32'(gnt_log.size() - gb), 32'd4);
        if (gnt_log.size() - gb == 4)
            check("fair_order", {8'(gnt_log[gb]), 8'(gnt_log[gb+1]), 8'(gnt_log[gb+2]), 8'(gnt_log[gb+3])}, 32'h00010001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
